fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit five-stage pipeline, sitting directly upstream of the decode stage. It holds the PC and issues word fetches to the instruction memory over a request/valid handshake. Fetched instructions and their PC go into a single output register that decode reads. A one-entry skid buffer absorbs in-flight returns while decode stalls, and the stage handles branch resolution (taken redirect or not-taken release) from the execute side.

---
 rtl/fetch_stage_if.sv | 42 ++++
 rtl/fetch_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//
// Purpose:
//     Request/valid handshake between the instruction-fetch stage and the
//     instruction memory. The fetch stage raises imem_req with imem_addr and
//     holds both stable until the memory pulses imem_valid for one cycle with
//     the returned word on imem_rdata. imem_valid may arrive in the same cycle
//     as imem_req (zero-wait memory).
//
// Signals:
//     imem_req    fetch -> memory   request outstanding
//     imem_addr   fetch -> memory   byte address of the fetch (16 bits)
//     imem_rdata  memory -> fetch   returned instruction (16 bits)
//     imem_valid  memory -> fetch   one-cycle completion pulse
//
// Modports:
//     master  the fetch stage
//     slave   the instruction memory
// ---------------------------------------------------------------------------
interface fetch_stage_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//     Instruction-fetch stage of the 16-bit five-stage pipeline, directly
//     upstream of decode. Holds the PC, issues word fetches over the
//     fetch_stage_if handshake, and presents each fetched instruction with
//     its PC in a single output register read by decode. A one-entry skid
//     buffer absorbs the return that is already in flight when decode
//     stalls. Branch resolution from the execute side either redirects the
//     PC (taken) or releases the held branch (not taken).
//
// Ports:
//     i_clk             clock, everything on its rising edge
//     i_reset           synchronous, active-high reset
//     imem              fetch_stage_if.master (req/addr out, rdata/valid in)
//     i_stall           decode cannot accept; output register holds
//     i_branch_resolve  one-cycle pulse: branch in decode has resolved
//     i_branch_taken    qualifies i_branch_resolve
//     i_branch_target   redirect PC, bit 0 forced to 0
//     o_ir              instruction to decode
//     o_pc_out          PC of o_ir
//     o_ir_valid        o_ir holds a real instruction, not a bubble
//     o_stall_cycles    (FETCH_PERF_CNT_EN only) cycles with stall and a
//                       valid instruction held, saturating
//     o_flush_count     (FETCH_PERF_CNT_EN only) taken resolves, saturating
//
// Configuration:
//     FETCH_PERF_CNT_EN  define to add the two saturating performance
//                        counters and their output ports. Undefined by
//                        default; behaviour is otherwise identical.
//
// States:
//     S_FETCH  request outstanding at the current PC
//     S_HOLD   skid full, decode stalled, no request issued
//     S_DRAIN  taken redirect pending; the old request is completed and its
//              return thrown away before fetching the saved target
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_IR   = 16'hF000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    fetch_stage_if.master        imem,
    input  logic                 i_stall,
    input  logic                 i_branch_resolve,
    input  logic                 i_branch_taken,
    input  logic [15:0]          i_branch_target,
    output logic [15:0]          o_ir,
    output logic [15:0]          o_pc_out,
    output logic                 o_ir_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]          o_stall_cycles,
    output logic [15:0]          o_flush_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_pc;          // address of the outstanding / next fetch
    logic [15:0] r_target;      // redirect PC saved while draining

    logic [15:0] r_ir;
    logic [15:0] r_pc_out;
    logic        r_ir_valid;

    logic        r_skid_full;
    logic [15:0] r_skid_ir;
    logic [15:0] r_skid_pc;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic        w_req;
    logic        w_ret;
    logic        w_out_free;
    logic        w_taken;
    logic        w_not_taken;
    logic [15:0] w_target;
    logic [15:0] w_pc_next;

    // A request is outstanding in FETCH and DRAIN. It is masked during the
    // reset cycle so the memory never sees a stale request from before reset.
    assign w_req       = (r_state != S_HOLD) && !i_reset;

    // A return only means something while a request is outstanding.
    assign w_ret       = imem.imem_valid && w_req;

    assign w_out_free  = !i_stall || !r_ir_valid;
    assign w_taken     = i_branch_resolve && i_branch_taken;
    assign w_not_taken = i_branch_resolve && !i_branch_taken;
    assign w_target    = i_branch_target & 16'hFFFE;
    assign w_pc_next   = r_pc + 16'd2;    // wraps modulo 2^16

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign o_ir       = r_ir;
    assign o_pc_out   = r_pc_out;
    assign o_ir_valid = r_ir_valid;

    // -----------------------------------------------------------------------
    // FSM, PC, output register and skid buffer
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge, regardless of order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_target    <= 16'h0000;
            r_ir        <= NOP_IR;
            r_pc_out    <= 16'h0000;
            r_ir_valid  <= 1'b0;
            r_skid_full <= 1'b0;
            // NOTE: the skid payload is deliberately not reset; r_skid_full
            // alone decides whether it is ever read.
        end else if (w_taken) begin
            // The branch leaves decode; the wrong-path work is dropped.
            r_ir        <= NOP_IR;
            r_ir_valid  <= 1'b0;
            r_skid_full <= 1'b0;
            if (w_req && !w_ret) begin
                // Memory still owes a word for the old address: wait for it
                // and throw it away before fetching the target.
                r_target <= w_target;
                r_state  <= S_DRAIN;
            end else begin
                // Nothing in flight (or it lands now and is discarded).
                r_pc    <= w_target;
                r_state <= S_FETCH;
            end
        end else if (w_not_taken && (r_state != S_DRAIN)) begin
            // The branch leaves decode even if decode is stalled: refill the
            // output from the oldest available instruction.
            if (r_skid_full) begin
                r_ir       <= r_skid_ir;
                r_pc_out   <= r_skid_pc;
                r_ir_valid <= 1'b1;
                if (w_ret) begin
                    r_skid_ir <= imem.imem_rdata;
                    r_skid_pc <= r_pc;
                    r_pc      <= w_pc_next;
                    r_state   <= S_HOLD;
                end else begin
                    r_skid_full <= 1'b0;
                    r_state     <= S_FETCH;
                end
            end else if (w_ret) begin
                r_ir       <= imem.imem_rdata;
                r_pc_out   <= r_pc;
                r_ir_valid <= 1'b1;
                r_pc       <= w_pc_next;
                r_state    <= S_FETCH;
            end else begin
                r_ir       <= NOP_IR;
                r_ir_valid <= 1'b0;
                r_state    <= S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ret) begin
                        r_pc <= w_pc_next;
                        if (w_out_free) begin
                            r_ir       <= imem.imem_rdata;
                            r_pc_out   <= r_pc;
                            r_ir_valid <= 1'b1;
                        end else begin
                            // Decode stalled with a word already in flight.
                            r_skid_ir   <= imem.imem_rdata;
                            r_skid_pc   <= r_pc;
                            r_skid_full <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (w_out_free) begin
                        r_ir       <= NOP_IR;
                        r_ir_valid <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (!i_stall) begin
                        r_ir        <= r_skid_ir;
                        r_pc_out    <= r_skid_pc;
                        r_ir_valid  <= 1'b1;
                        r_skid_full <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end

                S_DRAIN: begin
                    // Output already holds a bubble; only the stale return
                    // needs to complete.
                    if (w_ret) begin
                        r_pc    <= r_target;
                        r_state <= S_FETCH;
                    end
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cycles <= 16'h0000;
            r_flush_count  <= 16'h0000;
        end else begin
            if (i_stall && r_ir_valid && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_taken && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Purpose:
//     Self-checking bench for fetch_stage. The instruction memory returns
//     addr + 16'h1000 after a configurable (or random) number of wait
//     cycles. Directed table vectors cover streaming, stall/skid and branch
//     resolution; hand-written sequences cover drain, reset during HOLD, PC
//     wrap and the optional counters; a random phase is checked against a
//     program-order model of the instruction stream seen by decode.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_IR   = 16'hF000;
    localparam logic [15:0] MEM_OFS  = 16'h1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        resolve;
    logic        taken;
    logic [15:0] target;
    logic [15:0] ir;
    logic [15:0] pc_out;
    logic        irv;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_IR   (NOP_IR)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .imem             (imem_bus),
        .i_stall          (stall),
        .i_branch_resolve (resolve),
        .i_branch_taken   (taken),
        .i_branch_target  (target),
        .o_ir             (ir),
        .o_pc_out         (pc_out),
        .o_ir_valid       (irv)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_stall_cycles   (stall_cycles),
        .o_flush_count    (flush_count)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- instruction memory model ----------------
    int          mem_lat_cfg = 0;   // wait cycles per request, <0 = random 0..3
    bit          mem_busy    = 0;
    int          mem_wait    = 0;
    logic [15:0] mem_addr    = 16'h0000;

    // Called once per cycle after the inputs are set; drives the memory side
    // for the coming rising edge.
    task automatic mem_step();
        #1;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 16'($urandom);
        if (rst) begin
            mem_busy = 0;
        end else begin
            if (mem_busy) begin
                check1("req_held", imem_bus.imem_req, 1'b1);
                check16("addr_stable", imem_bus.imem_addr, mem_addr);
            end
            if (imem_bus.imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    mem_addr = imem_bus.imem_addr;
                    mem_wait = (mem_lat_cfg < 0) ? int'($urandom_range(3, 0)) : mem_lat_cfg;
                end
                if (mem_wait == 0) begin
                    imem_bus.imem_valid = 1'b1;
                    imem_bus.imem_rdata = mem_addr + MEM_OFS;
                    mem_busy = 0;
                end else begin
                    mem_wait--;
                end
            end
        end
    endtask

    // Two reset cycles, then the first post-reset cycle. Returns just after
    // the memory has been driven for that first cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; resolve = 1'b0; taken = 1'b0; target = 16'h0000;
        mem_step();
        @(negedge clk);
        mem_step();
        @(negedge clk);
        check1 ("rst_irv",    irv, 1'b0);
        check16("rst_ir",     ir, NOP_IR);
        check16("rst_pc_out", pc_out, 16'h0000);
        check1 ("rst_req",    imem_bus.imem_req, 1'b0);
        rst = 1'b0;
        mem_step();
        check1 ("boot_req",  imem_bus.imem_req, 1'b1);
        check16("boot_addr", imem_bus.imem_addr, RESET_PC);
    endtask

    // Advance until IR_VALID is seen (bounded). Returns at a falling edge
    // with inputs not yet applied for that cycle.
    task automatic wait_irv(input string name);
        int n;
        n = 0;
        @(negedge clk);
        resolve = 1'b0; taken = 1'b0;
        while (!irv && n < 20) begin
            mem_step();
            @(negedge clk);
            n++;
        end
        check1(name, irv, 1'b1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        stall;
        logic        resolve;
        logic        taken;
        logic [15:0] target;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_irv;
        logic [15:0] exp_ir;
        logic [15:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(logic s, logic r, logic t, logic [15:0] tg,
                                logic q, logic [15:0] a, logic v,
                                logic [15:0] x, logic [15:0] p);
        vec_t e;
        e.stall = s; e.resolve = r; e.taken = t; e.target = tg;
        e.exp_req = q; e.exp_addr = a; e.exp_irv = v; e.exp_ir = x; e.exp_pc = p;
        return e;
    endfunction

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          consumed;
        logic [15:0] exp_pc;

        rst = 1'b1; stall = 1'b0; resolve = 1'b0; taken = 1'b0; target = 16'h0000;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 16'h0000;

        // Outputs are observed at the falling edge before the row's inputs
        // are applied. Zero-wait memory returning addr + 16'h1000.
        //              stl res tkn target    req addr      irv ir        pc_out
        tbl[0]  = mk(0, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1000, 16'h0000);
        tbl[1]  = mk(1, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1002, 16'h0002); // return -> skid
        tbl[2]  = mk(1, 0, 0, 16'h0000, 0, 16'h0006, 1, 16'h1002, 16'h0002);
        tbl[3]  = mk(1, 0, 0, 16'h0000, 0, 16'h0006, 1, 16'h1002, 16'h0002);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 16'h0006, 1, 16'h1002, 16'h0002); // release
        tbl[5]  = mk(0, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h1004, 16'h0004); // skid word
        tbl[6]  = mk(0, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'h1006, 16'h0006);
        tbl[7]  = mk(1, 1, 0, 16'h0000, 1, 16'h000A, 1, 16'h1008, 16'h0008); // NT, skid empty
        tbl[8]  = mk(1, 0, 0, 16'h0000, 1, 16'h000C, 1, 16'h100A, 16'h000A); // return -> skid
        tbl[9]  = mk(1, 1, 0, 16'h0000, 0, 16'h000E, 1, 16'h100A, 16'h000A); // NT, skid full
        tbl[10] = mk(0, 0, 0, 16'h0000, 1, 16'h000E, 1, 16'h100C, 16'h000C);
        tbl[11] = mk(0, 1, 1, 16'h0041, 1, 16'h0010, 1, 16'h100E, 16'h000E); // taken, odd target
        tbl[12] = mk(0, 0, 0, 16'h0000, 1, 16'h0040, 0, NOP_IR,   16'h0000);
        tbl[13] = mk(0, 0, 0, 16'h0000, 1, 16'h0042, 1, 16'h1040, 16'h0040);

        mem_lat_cfg = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check1 ($sformatf("t%0d_req",  i), imem_bus.imem_req,  tbl[i].exp_req);
            check16($sformatf("t%0d_addr", i), imem_bus.imem_addr, tbl[i].exp_addr);
            check1 ($sformatf("t%0d_irv",  i), irv, tbl[i].exp_irv);
            check16($sformatf("t%0d_ir",   i), ir,  tbl[i].exp_ir);
            if (tbl[i].exp_irv)
                check16($sformatf("t%0d_pc", i), pc_out, tbl[i].exp_pc);
            stall   = tbl[i].stall;
            resolve = tbl[i].resolve;
            taken   = tbl[i].taken;
            target  = tbl[i].target;
            mem_step();
        end

        // ---- reset asserted while in HOLD ----
        @(negedge clk);
        stall = 1'b1; resolve = 1'b0; taken = 1'b0;
        mem_step();
        @(negedge clk);
        check1("hold_req", imem_bus.imem_req, 1'b0);
        rst = 1'b1;
        mem_step();
        @(negedge clk);
        check1 ("hrst_irv",    irv, 1'b0);
        check16("hrst_ir",     ir, NOP_IR);
        check16("hrst_pc_out", pc_out, 16'h0000);
        check1 ("hrst_req",    imem_bus.imem_req, 1'b0);
        rst = 1'b0; stall = 1'b0;
        mem_step();
        check1 ("hrst_boot_req",  imem_bus.imem_req, 1'b1);
        check16("hrst_boot_addr", imem_bus.imem_addr, RESET_PC);
        @(negedge clk);
        check1 ("hrst_first_irv", irv, 1'b1);
        check16("hrst_first_ir",  ir, 16'h1000);
        check16("hrst_first_pc",  pc_out, 16'h0000);
        mem_step();

        // ---- taken resolve with a request in flight (3 wait cycles) ----
        mem_lat_cfg = 3;
        do_reset();
        wait_irv("drain_wait_first");
        check16("drain_first_ir", ir, 16'h1000);
        resolve = 1'b1; taken = 1'b1; target = 16'h0040;
        mem_step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            resolve = 1'b0; taken = 1'b0;
            check1 ($sformatf("drain%0d_req", i),  imem_bus.imem_req, 1'b1);
            check16($sformatf("drain%0d_addr", i), imem_bus.imem_addr, 16'h0002);
            check1 ($sformatf("drain%0d_irv", i),  irv, 1'b0);
            mem_step();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1 ($sformatf("tgt%0d_req", i),  imem_bus.imem_req, 1'b1);
            check16($sformatf("tgt%0d_addr", i), imem_bus.imem_addr, 16'h0040);
            check1 ($sformatf("tgt%0d_irv", i),  irv, 1'b0);
            mem_step();
        end
        @(negedge clk);
        check1 ("tgt_irv", irv, 1'b1);
        check16("tgt_ir",  ir, 16'h1040);
        check16("tgt_pc",  pc_out, 16'h0040);
        mem_step();

        // ---- PC wrap from 16'hFFFE ----
        mem_lat_cfg = 0;
        do_reset();
        wait_irv("wrap_wait");
        resolve = 1'b1; taken = 1'b1; target = 16'hFFFF;
        mem_step();
        @(negedge clk);
        resolve = 1'b0; taken = 1'b0;
        check16("wrap_addr_fffe", imem_bus.imem_addr, 16'hFFFE);
        check1 ("wrap_bubble",    irv, 1'b0);
        mem_step();
        @(negedge clk);
        check16("wrap_addr_0000", imem_bus.imem_addr, 16'h0000);
        check1 ("wrap_irv",       irv, 1'b1);
        check16("wrap_ir",        ir, 16'h0FFE);
        check16("wrap_pc",        pc_out, 16'hFFFE);
        mem_step();

`ifdef FETCH_PERF_CNT_EN
        // ---- performance counters ----
        do_reset();
        check16("perf_rst_stall", stall_cycles, 16'h0000);
        check16("perf_rst_flush", flush_count, 16'h0000);
        wait_irv("perf_wait");
        stall = 1'b1;
        mem_step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_step();
        end
        @(negedge clk);
        stall = 1'b0;
        mem_step();
        for (int k = 0; k < 2; k++) begin
            wait_irv("perf_br_wait");
            resolve = 1'b1; taken = 1'b1; target = 16'h0100;
            mem_step();
        end
        @(negedge clk);
        resolve = 1'b0; taken = 1'b0;
        check16("perf_stall_cycles", stall_cycles, 16'd5);
        check16("perf_flush_count",  flush_count, 16'd2);
        mem_step();
`endif

        // ---- random phase against the program-order model ----
        // Every instruction leaving decode (valid and not stalled, or
        // resolved) must be the next one in program order: consecutive
        // addresses, restarting at the target after a taken branch.
        mem_lat_cfg = -1;
        do_reset();
        exp_pc   = RESET_PC;
        consumed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!irv) check16("rand_bubble_ir", ir, NOP_IR);
            stall   = ($urandom_range(99, 0) < 30);
            resolve = irv && ($urandom_range(99, 0) < 15);
            taken   = resolve && ($urandom_range(1, 0) == 1);
            target  = 16'($urandom);
            if (irv && (!stall || resolve)) begin
                check16("rand_pc", pc_out, exp_pc);
                check16("rand_ir", ir, exp_pc + MEM_OFS);
                exp_pc = taken ? (target & 16'hFFFE) : exp_pc + 16'd2;
                consumed++;
            end
            mem_step();
        end
        check1("rand_progress", consumed >= 300, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
